// File: rtl/fp16_mul_arbiter.sv
// Round-robin front end that shares one fixed-latency FP16 multiplier among NUM_REQ
// requesters, tracks in-flight tags and holds each result until the owner acks it.
module fp16_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned TAG_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    mul_valid,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    input  logic [15:0]             mul_result,
    input  logic [4:0]              mul_flags,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [16*NUM_REQ-1:0]   rsp_data,
    output logic [5*NUM_REQ-1:0]    rsp_flags,
    input  logic [NUM_REQ-1:0]      rsp_ack,
    output logic [TAG_W:0]          busy_count
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned CNT_W  = TAG_W + 1;

    logic [MUL_LATENCY-1:0] pipe_vld;
    logic [TAG_W-1:0]       pipe_tag [MUL_LATENCY];
    logic [NUM_REQ-1:0]     inflight;
    logic [NUM_REQ-1:0]     inflight_nxt;
    logic [NUM_REQ-1:0]     rsp_valid_nxt;
    logic [NUM_REQ-1:0]     busy;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     exit_vec;
    logic [TAG_W-1:0]       last_grant;
    logic [TAG_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [CNT_W-1:0]       busy_cnt_nxt;
    int unsigned            idx;

    // Busy comes from registered state only, so an ack frees the slot one cycle later.
    assign busy     = inflight | rsp_valid;
    assign eligible = req_valid & ~busy;

    // Round-robin search starting just after the last accepted grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(last_grant) + k + 32'd1) % NUM_REQ;
            if (!grant_any && !rst && eligible[TAG_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(idx);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign req_ready = grant;
    assign mul_valid = grant_any;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                mul_a = req_a[k*DATA_W +: DATA_W];
                mul_b = req_b[k*DATA_W +: DATA_W];
            end
        end
    end

    // Per-requester next state: accept sets inflight, tag exit moves it to the response slot.
    always_comb begin
        exit_vec = '0;
        if (pipe_vld[MUL_LATENCY-1]) exit_vec[pipe_tag[MUL_LATENCY-1]] = 1'b1;
        inflight_nxt  = (inflight | grant) & ~exit_vec;
        rsp_valid_nxt = (rsp_valid & ~rsp_ack) | exit_vec;
        busy_cnt_nxt  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            busy_cnt_nxt = busy_cnt_nxt + CNT_W'(inflight_nxt[k] | rsp_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld   <= '0;
            for (int unsigned s = 0; s < MUL_LATENCY; s++) pipe_tag[s] <= '0;
            inflight   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            last_grant <= TAG_W'(NUM_REQ - 1);
            busy_count <= '0;
        end else begin
            pipe_vld[0] <= grant_any;
            pipe_tag[0] <= grant_idx;
            for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
            inflight   <= inflight_nxt;
            rsp_valid  <= rsp_valid_nxt;
            busy_count <= busy_cnt_nxt;
            if (grant_any) last_grant <= grant_idx;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (exit_vec[k]) begin
                    rsp_data[k*DATA_W +: DATA_W]  <= mul_result;
                    rsp_flags[k*FLAG_W +: FLAG_W] <= mul_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Scoreboard bench for fp16_mul_arbiter with a behavioural fixed-latency FP16 multiplier.
module tb_fp16_mul_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 3;
    localparam int unsigned TAG_W   = 2;
    localparam logic [15:0] FLAG_A  = 16'h5A00;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [16*NUM_REQ-1:0] req_a = '0;
    logic [16*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mul_valid;
    logic [15:0]           mul_a, mul_b, mul_result;
    logic [4:0]            mul_flags;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [16*NUM_REQ-1:0] rsp_data;
    logic [5*NUM_REQ-1:0]  rsp_flags;
    logic [NUM_REQ-1:0]    rsp_ack;
    logic [TAG_W:0]        busy_count;
    logic [NUM_REQ-1:0]    ack_mask = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          tag;
        logic [15:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];

    fp16_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_flags(mul_flags), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_ack(rsp_ack), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    assign rsp_ack = rsp_valid & ack_mask;

    // Truncating FP16 multiply, valid for normal operands with in-range products.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [6:0]  e;
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = 7'(a[14:10]) + 7'(b[14:10]) - 7'd15;
        if (p[21]) return {a[15] ^ b[15], 5'(e + 7'd1), p[20:11]};
        return {a[15] ^ b[15], 5'(e), p[19:10]};
    endfunction

    function automatic logic [4:0] fflags(input logic [15:0] a);
        return (a == FLAG_A) ? 5'b10010 : 5'b00000;
    endfunction

    logic [15:0] mres [LAT];
    logic [4:0]  mflg [LAT];

    always @(posedge clk) begin
        mres[0] <= mul_valid ? fmul(mul_a, mul_b) : 16'hDEAD;
        mflg[0] <= mul_valid ? fflags(mul_a) : 5'b01111;
        for (int s = 1; s < LAT; s++) begin
            mres[s] <= mres[s-1];
            mflg[s] <= mflg[s-1];
        end
    end

    assign mul_result = mres[LAT-1];
    assign mul_flags  = mflg[LAT-1];

    logic [NUM_REQ-1:0] prev_rsp = '0;
    int   mon_g;
    exp_t mon_e;

    // Issue monitor pushes expectations; each rising rsp_valid pops and compares.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_rsp = '0;
        end else begin
            if (req_ready != '0) begin
                mon_g = 0;
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) mon_g = k;
                checks++;
                if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0 || mul_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL grant_onehot: req_ready=%b req_valid=%b mul_valid=%b", req_ready, req_valid, mul_valid);
                end
                checks++;
                if (mul_a !== req_a[mon_g*16 +: 16] || mul_b !== req_b[mon_g*16 +: 16]) begin
                    errors++;
                    $display("FAIL issue_operands: got %h/%h expected %h/%h", mul_a, mul_b,
                             req_a[mon_g*16 +: 16], req_b[mon_g*16 +: 16]);
                end
                mon_e.tag   = mon_g;
                mon_e.data  = fmul(req_a[mon_g*16 +: 16], req_b[mon_g*16 +: 16]);
                mon_e.flags = fflags(req_a[mon_g*16 +: 16]);
                sb.push_back(mon_e);
                grant_log.push_back(mon_g);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (rsp_valid[k] && !prev_rsp[k]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: rsp_valid[%0d] rose with nothing in flight", k);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.tag != k || rsp_data[k*16 +: 16] !== mon_e.data || rsp_flags[k*5 +: 5] !== mon_e.flags) begin
                            errors++;
                            $display("FAIL rsp_result: slot %0d data %h flags %b, expected slot %0d data %h flags %b",
                                     k, rsp_data[k*16 +: 16], rsp_flags[k*5 +: 5], mon_e.tag, mon_e.data, mon_e.flags);
                        end
                    end
                end
            end
            prev_rsp = rsp_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; ack_mask = '0; req_a = '0; req_b = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
    endtask

    task automatic drain();
        req_valid = '0;
        ack_mask  = '1;
        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (sb.size() != 0 || rsp_valid !== '0 || busy_count !== '0) begin
            errors++;
            $display("FAIL drain: pending=%0d rsp_valid=%b busy_count=%0d expected 0/0/0", sb.size(), rsp_valid, busy_count);
        end
    endtask

    task automatic test_single_op();
        @(posedge clk); #1;
        req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000; req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || mul_valid !== 1'b1 || mul_a !== 16'h3C00 || mul_b !== 16'h4000) begin
            errors++;
            $display("FAIL single_issue: ready=%b valid=%b a=%h b=%h expected 0001 1 3c00 4000", req_ready, mul_valid, mul_a, mul_b);
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            checks++;
            if (rsp_valid[0] !== 1'(k == LAT + 1) || busy_count !== 3'd1) begin
                errors++;
                $display("FAIL single_latency: edge %0d rsp_valid=%b busy_count=%0d expected %0d and 1",
                         k, rsp_valid[0], busy_count, (k == LAT + 1));
            end
        end
        checks++;
        if (rsp_data[15:0] !== 16'h4000) begin
            errors++;
            $display("FAIL single_data: got %h expected 4000", rsp_data[15:0]);
        end
        ack_mask = 4'b0001;
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || busy_count !== 3'd0 || rsp_data[15:0] !== 16'h4000) begin
            errors++;
            $display("FAIL single_ack: rsp_valid=%b busy_count=%0d data=%h expected 0000 0 4000", rsp_valid, busy_count, rsp_data[15:0]);
        end
        ack_mask = '0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_grant: req_ready=%b mul_valid=%b expected 0", req_ready, mul_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy_count !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_flags !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0d rsp_valid=%b data=%h flags=%h expected all 0", busy_count, rsp_valid, rsp_data, rsp_flags);
        end
        grant_log.delete();
    endtask

    task automatic test_fairness();
        int cyc;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*16 +: 16] = 16'(16'h3C00 + i * 256);
            req_b[i*16 +: 16] = 16'(16'h4000 + i * 64);
        end
        ack_mask = '1; req_valid = '1;
        cyc = 0;
        while (grant_log.size() < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if (grant_log.size() < 12) begin
            errors++;
            $display("FAIL fair_timeout: %0d grants seen, expected 12", grant_log.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (grant_log[k] != k % NUM_REQ) begin
                    errors++;
                    $display("FAIL fair_order: grant %0d went to %0d expected %0d", k, grant_log[k], k % NUM_REQ);
                end
            end
        end
        drain();
    endtask

    task automatic test_blocking();
        int cyc;
        do_reset();
        req_a[47:32] = 16'h4200; req_b[47:32] = 16'h4400; req_valid = 4'b0100;
        cyc = 0;
        while (rsp_valid[2] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (rsp_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL blk_timeout: rsp_valid[2]=%b expected 1", rsp_valid[2]);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (req_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL blk_hold: req_ready[2]=%b expected 0", req_ready[2]);
            end
        end
        @(posedge clk); #1;
        ack_mask = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL blk_ack_cycle: req_ready[2]=%b rsp_valid[2]=%b expected 0 1", req_ready[2], rsp_valid[2]);
        end
        @(posedge clk); #1;
        ack_mask = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL blk_after_ack: req_ready=%b expected 0100", req_ready);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_sparse();
        int cyc;
        do_reset();
        req_a[31:16] = 16'h3E00; req_b[31:16] = 16'h3C00;
        req_a[63:48] = 16'h4100; req_b[63:48] = 16'h4000;
        ack_mask = '1; req_valid = 4'b1010;
        cyc = 0;
        while (grant_log.size() < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if (grant_log.size() < 6) begin
            errors++;
            $display("FAIL sparse_timeout: %0d grants seen, expected 6", grant_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (grant_log[k] != ((k % 2 == 0) ? 1 : 3)) begin
                    errors++;
                    $display("FAIL sparse_order: grant %0d went to %0d expected %0d", k, grant_log[k], (k % 2 == 0) ? 1 : 3);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4400;
        req_a[31:16] = 16'h4000; req_b[31:16] = 16'h4000;
        ack_mask = '1;
        @(posedge clk); #1;
        req_valid = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (grant_log.size() != 2) begin
            errors++;
            $display("FAIL mid_issue: %0d grants before reset, expected 2", grant_log.size());
        end
        repeat (LAT + 3) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== '0 || busy_count !== '0) begin
                errors++;
                $display("FAIL mid_quiet: rsp_valid=%b busy_count=%0d expected 0 0", rsp_valid, busy_count);
            end
        end
        @(posedge clk); #1;
        req_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_next_grant: req_ready=%b expected 0001", req_ready);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_flags();
        do_reset();
        req_a[15:0] = 16'h3E00; req_b[15:0] = 16'h4100;
        req_a[63:48] = FLAG_A;  req_b[63:48] = 16'h3C00;
        ack_mask = '0; req_valid = 4'b1001;
        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b1001 || rsp_flags[19:15] !== 5'b10010 || rsp_data[63:48] !== 16'h5A00) begin
            errors++;
            $display("FAIL flags_slot3: rsp_valid=%b flags=%b data=%h expected 1001 10010 5a00",
                     rsp_valid, rsp_flags[19:15], rsp_data[63:48]);
        end
        checks++;
        if (rsp_flags[14:0] !== 15'd0 || rsp_data[15:0] !== 16'h4380 || rsp_data[47:16] !== 32'd0) begin
            errors++;
            $display("FAIL flags_others: flags=%b data0=%h data12=%h expected 0 4380 0",
                     rsp_flags[14:0], rsp_data[15:0], rsp_data[47:16]);
        end
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        do_reset();
        test_single_op();
        test_reset();
        test_fairness();
        test_blocking();
        test_sparse();
        test_reset_midflight();
        test_flags();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d results never returned", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
